// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: mode encodings, output-register states and the rotated first-set search shared by stream_mux.
package stream_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  localparam int MAX_W = 6;
  localparam int MAX_CH = 1 << MAX_W;
  typedef enum logic {EMPTY, FULL} ostate_t;
  // Index of the first set bit in req[n-1:0], searching upward from start and wrapping; -1 when none set.
  function automatic int first_set(input logic [MAX_CH-1:0] req, input int start, input int n);
    int r;
    int idx;
    r = -1;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = start + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[MAX_W-1:0]]) r = idx;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: round-robin grant over CHANNELS requests; rr_ptr remembers the last channel that transferred.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_any
);
  logic [SEL_W-1:0] rr_ptr;
  logic [MAX_CH-1:0] req_ext;
  int pick;
  always_comb begin
    req_ext = '0;
    req_ext[CHANNELS-1:0] = req;
    pick = first_set(req_ext, (int'(rr_ptr) == CHANNELS - 1) ? 0 : int'(rr_ptr) + 1, CHANNELS);
    grant_any = pick >= 0;
    grant_idx = grant_any ? SEL_W'(pick) : '0;
    grant = grant_any ? CHANNELS'(1) << grant_idx : '0;
  end
  // Reset to the last channel so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= SEL_W'(CHANNELS - 1);
    else if (advance) rr_ptr <= grant_idx;
endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-channel registered valid/ready multiplexer, fixed select or round-robin (round-robin built only with STREAM_MUX_RR_EN).
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      rr_mode,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  input  logic                      out_ready
);
  ostate_t state, state_nx;
  logic can_load, xfer, fx_any, g_any;
  logic [SEL_W-1:0] g_idx;
  logic [CHANNELS-1:0] fx_oh, g_oh;
  logic [(1<<SEL_W)-1:0] v_ext;
  // Widened valid vector so an out-of-range sel simply reads as not valid.
  always_comb begin
    v_ext = '0;
    v_ext[CHANNELS-1:0] = in_valid;
    fx_any = (int'(sel) < CHANNELS) && v_ext[sel];
    fx_oh = fx_any ? CHANNELS'(1) << sel : '0;
  end
`ifdef STREAM_MUX_RR_EN
  logic rr_any;
  logic [SEL_W-1:0] rr_idx;
  logic [CHANNELS-1:0] rr_oh;
  rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(in_valid),
    .advance(xfer && rr_mode == MODE_RR),
    .grant(rr_oh),
    .grant_idx(rr_idx),
    .grant_any(rr_any)
  );
  assign g_any = rr_mode == MODE_RR ? rr_any : fx_any;
  assign g_idx = rr_mode == MODE_RR ? rr_idx : sel;
  assign g_oh = rr_mode == MODE_RR ? rr_oh : fx_oh;
`else
  logic unused_rr_mode;
  assign unused_rr_mode = rr_mode;
  assign g_any = fx_any;
  assign g_idx = sel;
  assign g_oh = fx_oh;
`endif
  assign can_load = state == EMPTY || out_ready;
  assign in_ready = (rst_n && can_load && g_any) ? g_oh : '0;
  assign xfer = |(in_valid & in_ready);
  assign out_valid = state == FULL;
  always_comb state_nx = xfer ? FULL : (out_ready ? EMPTY : state);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  // Data and channel only move on an input transfer; draining leaves them as they were.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_data <= '0;
      out_ch <= '0;
    end else if (xfer) begin
      out_data <= in_data[int'(g_idx)*WIDTH +: WIDTH];
      out_ch <= g_idx;
    end
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: directed checks of stream_mux (WIDTH=8, CHANNELS=4); round-robin checks when STREAM_MUX_RR_EN is defined.
module tb_stream_mux;
  logic clk = 0;
  logic rst_n = 0;
  logic [3:0] in_valid = 0;
  logic [31:0] in_data;
  logic [3:0] in_ready;
  logic [1:0] sel = 0;
  logic rr_mode = 0;
  logic out_valid;
  logic [7:0] out_data;
  logic [1:0] out_ch;
  logic out_ready = 0;
  logic [7:0] d [4];
  int vecs = 0;
  int errs = 0;
  assign in_data = {d[3], d[2], d[1], d[0]};
  always #5 clk = ~clk;
  stream_mux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .sel(sel),
    .rr_mode(rr_mode),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ch(out_ch),
    .out_ready(out_ready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'hA5; d[3] = 8'h33;
    sel = 2; in_valid = 4'b1111; out_ready = 1;
    settle();
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_ch", out_ch, 0);
    tick();
    rst_n = 1;
    settle();
    check("fix ready0", in_ready, 4'b0100);
    tick();
    check("fix valid1", out_valid, 1);
    check("fix data1", out_data, 8'hA5);
    check("fix ch1", out_ch, 2);
    check("fix ready1", in_ready, 4'b0100);
    d[2] = 8'h5A;
    tick();
    check("fix data2", out_data, 8'h5A);
    check("fix valid2", out_valid, 1);
    out_ready = 0; d[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp ready", in_ready, 0);
      check("bp data", out_data, 8'h5A);
      check("bp valid", out_valid, 1);
      tick();
    end
    out_ready = 1;
    settle();
    check("bp release ready", in_ready, 4'b0100);
    tick();
    check("bp reload data", out_data, 8'hC3);
    sel = 3; in_valid = 4'b0111;
    settle();
    check("sel3 ready", in_ready, 0);
    tick();
    check("sel3 drained", out_valid, 0);
    check("sel3 data hold", out_data, 8'hC3);
    check("sel3 ch hold", out_ch, 2);
    sel = 1; in_valid = 4'b0010;
    settle();
    check("sel1 ready", in_ready, 4'b0010);
    tick();
    check("sel1 data", out_data, 8'h22);
    check("sel1 ch", out_ch, 1);
    check("sel1 valid", out_valid, 1);
    rst_n = 0;
    settle();
    check("midrst valid", out_valid, 0);
    check("midrst data", out_data, 0);
    check("midrst ch", out_ch, 0);
    check("midrst ready", in_ready, 0);
    tick();
    rst_n = 1;
`ifdef STREAM_MUX_RR_EN
    rr_mode = 1; in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);
    for (int k = 0; k < 5; k++) begin
      settle();
      check("rr grant", in_ready, 4'b0001 << (k % 4));
      tick();
      check("rr out_ch", out_ch, k % 4);
      check("rr out_data", out_data, 8'h10 + (k % 4));
    end
    in_valid = 4'b1010;
    settle();
    check("rr fair g1", in_ready, 4'b0010);
    tick();
    settle();
    check("rr fair g3", in_ready, 4'b1000);
    tick();
    check("rr fair ch3", out_ch, 3);
    settle();
    check("rr fair g1b", in_ready, 4'b0010);
    tick();
    in_valid = 0;
    settle();
    check("rr idle ready", in_ready, 0);
    tick();
    check("rr idle drained", out_valid, 0);
    in_valid = 4'b1010;
    settle();
    check("rr after idle g3", in_ready, 4'b1000);
    tick();
    check("rr after idle ch", out_ch, 3);
`else
    rr_mode = 1; sel = 0; in_valid = 4'b1110;
    settle();
    check("nrr ignored ready", in_ready, 0);
    sel = 3;
    settle();
    check("nrr sel3 ready", in_ready, 4'b1000);
    tick();
    check("nrr sel3 ch", out_ch, 3);
    check("nrr sel3 data", out_data, 8'h33);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel registered multiplexer with valid/ready handshake on every input and on the output. It generalises the team's 2:1 gate-level mux into a streaming selector: one clock, one registered output stage, a fixed-select mode and an optional round-robin arbitration mode. It sits between several producer streams and a single consumer, such as a shared bus port or a shared processing lane.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SEL_W, localparam = $clog2(CHANNELS), select/channel-index width
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous assert, active-low
- in_valid  input  CHANNELS  per-channel data valid
- in_data  input  CHANNELS*WIDTH  packed data; channel i occupies [i*WIDTH +: WIDTH]
- in_ready  output  CHANNELS  per-channel accept; at most one bit high per cycle
- sel  input  SEL_W  channel index used in fixed mode
- rr_mode  input  1  1 = round-robin arbitration, 0 = fixed select
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered data
- out_ch  output  SEL_W  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts the output word

## Operation
- Output register has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_load = !out_valid | out_ready.
- Grant, computed combinationally each cycle:
  - Fixed mode: grant = sel when in_valid[sel]=1; otherwise no grant.
  - RR mode: first channel with in_valid=1, searched from rr_ptr+1 upward, wrapping at CHANNELS-1 to 0.
- in_ready[i] = can_load & (grant==i). A transfer on channel i is in_valid[i] & in_ready[i].
- On an input transfer: out_data←that channel's data, out_ch←i, out_valid←1. In RR mode rr_ptr←i.
- On an output transfer without a simultaneous input transfer: out_valid←0. out_data and out_ch hold their values.
- Output transfer and input transfer in the same cycle: the register reloads and out_valid stays 1. Full throughput of one word per cycle.
- sel ≥ CHANNELS (non-power-of-two CHANNELS): no grant and no in_ready. This is not an error.
- sel and rr_mode changes affect only the next grant. A word already held in the register is never altered.
- rr_ptr advances only on an input transfer. An idle cycle, or an in_valid that is not granted, leaves it unchanged.
- in_ready depends on in_valid and out_ready combinationally. in_valid must not depend on in_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=CHANNELS-1, so channel 0 has first priority after reset. in_ready is all 0 while rst_n=0.
- Latency: input transfer at edge N gives out_valid=1 with the data after edge N.
- Reset asserted mid-operation: the held word is discarded immediately, without waiting for an edge. Deassertion is synchronised externally.
- Back-pressure: while out_valid=1 and out_ready=0, all in_ready bits are 0, and out_data and out_ch are stable.

## Configuration
- STREAM_MUX_RR_EN defined: round-robin logic and rr_ptr are compiled in, and rr_mode behaves as described above.
- Not defined: rr_ptr and the search logic are absent, rr_mode is ignored, and the block is fixed-select only.

## Structure
- Shared package stream_mux_pkg holds the mode encoding constants MODE_FIXED=1'b0 and MODE_RR=1'b1, plus a function returning the index of the first set bit from a rotated start position.
- Sub-module rr_arbiter (CHANNELS parameter) holds rr_ptr and produces the one-hot grant. It is instantiated only under STREAM_MUX_RR_EN.

## Test plan
- Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 immediately.
- Fixed mode, CHANNELS=4, sel=2, in_valid=4'b1111, data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100 each cycle, out_data=8'hA5 and out_ch=2 one cycle later, one word per cycle.
- Back-pressure: out_ready=0 for 3 cycles while FULL -> in_ready=0, out_data stable; out_ready=1 -> the next word loads in the same cycle.
- Round-robin, all in_valid=1 after reset -> grants 0,1,2,3,0 on consecutive cycles, with out_ch following one cycle behind.
- Round-robin fairness: in_valid=4'b1010, rr_ptr=1 -> grant 3, then 1, then 3; rr_ptr unchanged across an idle cycle with in_valid=0.
- Fixed mode, sel=3, in_valid[3]=0, other channels valid -> no in_ready, out_valid drops after the current word drains.
